// File: rtl/picobello_pkg.sv
// Shared types and constants for the multicast AW decode path.
// Contents:
//   - address-map, mask-select and AW user-bit types
//   - mcast_dec_t: one decoded request (destination, masks, B count, error flags)
//   - skid_state_e: occupancy states of the output skid buffer
//   - SamMcast: default multicast system address map
//   - popcount: helper used to derive the expected B count
package picobello_pkg;

  localparam int unsigned AxiAddrWidth     = 32;
  localparam int unsigned AtopWidth        = 6;
  localparam int unsigned McastMaxMaskLen  = 6;
  localparam int unsigned McastNumDstWidth = 2 * McastMaxMaskLen + 1;
  localparam int unsigned SamNumRules      = 3;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
  } id_t;

  typedef struct packed {
    logic [5:0] offset;
    logic [5:0] len;
  } mask_sel_t;

  typedef struct packed {
    logic [AxiAddrWidth-1:0] mcast_mask;
    logic [AtopWidth-1:0]    atomic;
  } mcast_user_t;

  typedef struct packed {
    id_t                     idx;
    logic [AxiAddrWidth-1:0] start_addr;
    logic [AxiAddrWidth-1:0] end_addr;
    mask_sel_t               mask_x;
    mask_sel_t               mask_y;
  } sam_multicast_rule_t;

  typedef struct packed {
    id_t                         dst;
    logic [McastMaxMaskLen-1:0]  mask_x;
    logic [McastMaxMaskLen-1:0]  mask_y;
    logic [McastNumDstWidth-1:0] num_dst;
    logic                        decerr;
    logic                        mcast_err;
  } mcast_dec_t;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

  // Rule 1 overlaps rule 0 on purpose: the lower index has priority, so
  // rule 1 only answers for addresses past the end of rule 0.
  // Rule 2 has no mask fields at all (unicast-only region).
  localparam sam_multicast_rule_t [SamNumRules-1:0] SamMcast = '{
    2: '{idx: '{x: 4'd3, y: 4'd3},
         start_addr: 32'h7000_0000, end_addr: 32'h7001_0000,
         mask_x: '{offset: 6'd0, len: 6'd0},
         mask_y: '{offset: 6'd0, len: 6'd0}},
    1: '{idx: '{x: 4'd2, y: 4'd2},
         start_addr: 32'h2000_0000, end_addr: 32'h3000_0000,
         mask_x: '{offset: 6'd16, len: 6'd3},
         mask_y: '{offset: 6'd12, len: 6'd1}},
    0: '{idx: '{x: 4'd1, y: 4'd1},
         start_addr: 32'h2000_0000, end_addr: 32'h2004_0000,
         mask_x: '{offset: 6'd20, len: 6'd2},
         mask_y: '{offset: 6'd18, len: 6'd2}}
  };

  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] cnt;
    cnt = '0;
    for (int i = 0; i < 32; i++) begin
      cnt = cnt + 6'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/picobello_mcast_rule_match.sv
// Combinational multicast rule lookup and mask extraction.
// Ports:
//   addr_i  - AW address to look up
//   user_i  - AW user bits (mcast_user_t: mcast_mask, atomic)
//   dec_o   - decoded request (mcast_dec_t)
module picobello_mcast_rule_match
  import picobello_pkg::*;
#(
  parameter int unsigned AddrWidth  = AxiAddrWidth,
  parameter int unsigned NumRules   = SamNumRules,
  parameter int unsigned MaxMaskLen = McastMaxMaskLen,
  parameter sam_multicast_rule_t [NumRules-1:0] RuleTable = SamMcast
) (
  input  logic [AddrWidth-1:0]           addr_i,
  input  logic [$bits(mcast_user_t)-1:0] user_i,
  output logic [$bits(mcast_dec_t)-1:0]  dec_o
);

  mcast_user_t          user;
  mcast_dec_t           dec;
  logic                 hit;
  id_t                  hit_idx;
  mask_sel_t            sel_x;
  mask_sel_t            sel_y;
  logic [AddrWidth-1:0] field_x;
  logic [AddrWidth-1:0] field_y;
  logic [AddrWidth-1:0] in_fields;
  logic                 outside_err;
  logic                 atomic_err;
  logic [5:0]           pop_sum;

  assign user  = mcast_user_t'(user_i);
  assign dec_o = dec;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    sel_x   = '0;
    sel_y   = '0;
    // Walk from the top index down so the lowest matching rule is the last
    // one written and therefore wins.
    for (int i = NumRules - 1; i >= 0; i--) begin
      if (addr_i >= RuleTable[i].start_addr && addr_i < RuleTable[i].end_addr) begin
        hit     = 1'b1;
        hit_idx = RuleTable[i].idx;
        sel_x   = RuleTable[i].mask_x;
        sel_y   = RuleTable[i].mask_y;
      end
    end

    // Shifting an all-ones vector left by len leaves exactly len low zeros,
    // so its complement is the field mask (empty for len = 0).
    field_x = (user.mcast_mask >> sel_x.offset) & ~({AddrWidth{1'b1}} << sel_x.len);
    field_y = (user.mcast_mask >> sel_y.offset) & ~({AddrWidth{1'b1}} << sel_y.len);

    // Any mask bit not covered by either selected field is illegal.
    in_fields   = (field_x << sel_x.offset) | (field_y << sel_y.offset);
    outside_err = |(user.mcast_mask & ~in_fields);
    atomic_err  = (|user.atomic) & (|user.mcast_mask);

    pop_sum = popcount(32'(field_x[MaxMaskLen-1:0])) + popcount(32'(field_y[MaxMaskLen-1:0]));

    dec           = '0;
    dec.dst       = hit ? hit_idx : '0;
    dec.decerr    = ~hit;
    dec.mcast_err = hit & (outside_err | atomic_err);
    // Errored requests still travel downstream as a single unicast so one
    // error B comes back.
    if (dec.decerr || dec.mcast_err) begin
      dec.num_dst = McastNumDstWidth'(1);
    end else begin
      dec.mask_x  = field_x[MaxMaskLen-1:0];
      dec.mask_y  = field_y[MaxMaskLen-1:0];
      dec.num_dst = McastNumDstWidth'(1) << pop_sum;
    end

    assert (!hit || (int'(sel_x.offset) + int'(sel_x.len) <= int'(AddrWidth)));
    assert (!hit || (int'(sel_y.offset) + int'(sel_y.len) <= int'(AddrWidth)));
  end

endmodule

// File: rtl/picobello_mcast_aw_decoder.sv
// Pipelined multicast AW decode stage with a 2-entry output skid buffer.
// Ports:
//   clk_i, rst_ni        - clock, asynchronous active-low reset
//   req_valid_i/_ready_o - AW request handshake (ready is a flop, not fed by rsp_ready_i)
//   req_addr_i           - AW address
//   req_user_i           - AW user bits (mcast_mask, atomic)
//   rsp_valid_o/_ready_i - decoded request handshake
//   rsp_dst_o            - base destination id of the matched rule
//   rsp_mask_x_o/_y_o    - extracted X/Y masks
//   rsp_num_dst_o        - number of B responses to expect
//   rsp_decerr_o         - no rule matched
//   rsp_mcast_err_o      - illegal multicast mask
module picobello_mcast_aw_decoder
  import picobello_pkg::*;
#(
  parameter int unsigned AddrWidth  = AxiAddrWidth,
  parameter int unsigned NumRules   = SamNumRules,
  parameter int unsigned MaxMaskLen = McastMaxMaskLen,
  parameter sam_multicast_rule_t [NumRules-1:0] RuleTable = SamMcast
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  logic [AddrWidth-1:0]           req_addr_i,
  input  logic [$bits(mcast_user_t)-1:0] req_user_i,
  output logic                           rsp_valid_o,
  input  logic                           rsp_ready_i,
  output logic [$bits(id_t)-1:0]         rsp_dst_o,
  output logic [MaxMaskLen-1:0]          rsp_mask_x_o,
  output logic [MaxMaskLen-1:0]          rsp_mask_y_o,
  output logic [2*MaxMaskLen:0]          rsp_num_dst_o,
  output logic                           rsp_decerr_o,
  output logic                           rsp_mcast_err_o
);

  mcast_dec_t  dec;
  mcast_dec_t  main_q, main_d;
  mcast_dec_t  skid_q, skid_d;
  skid_state_e state_q, state_d;
  logic        ready_q, ready_d;
  logic        accept;
  logic        consume;

  picobello_mcast_rule_match #(
    .AddrWidth (AddrWidth),
    .NumRules  (NumRules),
    .MaxMaskLen(MaxMaskLen),
    .RuleTable (RuleTable)
  ) i_rule_match (
    .addr_i(req_addr_i),
    .user_i(req_user_i),
    .dec_o (dec)
  );

  assign accept  = req_valid_i & ready_q;
  assign consume = (state_q != SKID_EMPTY) & rsp_ready_i;

  // main always holds the oldest entry and drives the outputs; skid only
  // fills when a request arrives while main is stalled.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      SKID_EMPTY: begin
        if (accept) begin
          main_d  = dec;
          state_d = SKID_ONE;
        end
      end
      SKID_ONE: begin
        if (accept && consume) begin
          main_d = dec;
        end else if (accept) begin
          skid_d  = dec;
          state_d = SKID_FULL;
        end else if (consume) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        if (consume) begin
          main_d  = skid_q;
          state_d = SKID_ONE;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
    // Ready is registered from the next state so rsp_ready_i never reaches
    // req_ready_o combinationally.
    ready_d = (state_d != SKID_FULL);
  end

  // State, entries and ready flag; ready stays low throughout reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SKID_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
    end
  end

  assign req_ready_o     = ready_q;
  assign rsp_valid_o     = (state_q != SKID_EMPTY);
  assign rsp_dst_o       = main_q.dst;
  assign rsp_mask_x_o    = main_q.mask_x;
  assign rsp_mask_y_o    = main_q.mask_y;
  assign rsp_num_dst_o   = main_q.num_dst;
  assign rsp_decerr_o    = main_q.decerr;
  assign rsp_mcast_err_o = main_q.mcast_err;

endmodule

// File: tb/tb_picobello_mcast_aw_decoder.sv
// Self-checking bench for picobello_mcast_aw_decoder.
// A queue of expected decodes is filled from a per-bit address-map model on
// every accepted request and drained on every consumed response; the DUT
// outputs are compared against its head on every falling edge.
module tb_picobello_mcast_aw_decoder;
  import picobello_pkg::*;

  logic                           clk_i       = 1'b0;
  logic                           rst_ni      = 1'b0;
  logic                           req_valid_i = 1'b0;
  logic                           req_ready_o;
  logic [31:0]                    req_addr_i  = '0;
  logic [$bits(mcast_user_t)-1:0] req_user_i  = '0;
  logic                           rsp_valid_o;
  logic                           rsp_ready_i = 1'b0;
  logic [7:0]                     rsp_dst_o;
  logic [5:0]                     rsp_mask_x_o;
  logic [5:0]                     rsp_mask_y_o;
  logic [12:0]                    rsp_num_dst_o;
  logic                           rsp_decerr_o;
  logic                           rsp_mcast_err_o;

  int         checks = 0;
  int         errors = 0;
  mcast_dec_t exp_q[$];
  bit         armed  = 1'b0;

  picobello_mcast_aw_decoder dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_addr_i     (req_addr_i),
    .req_user_i     (req_user_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_dst_o      (rsp_dst_o),
    .rsp_mask_x_o   (rsp_mask_x_o),
    .rsp_mask_y_o   (rsp_mask_y_o),
    .rsp_num_dst_o  (rsp_num_dst_o),
    .rsp_decerr_o   (rsp_decerr_o),
    .rsp_mcast_err_o(rsp_mcast_err_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference decode: classify every mask bit individually against the
  // first rule whose range holds the address.
  function automatic mcast_dec_t model(input logic [31:0] addr, input logic [$bits(mcast_user_t)-1:0] user);
    mcast_user_t u;
    mcast_dec_t  r;
    int          hit;
    int          ox, lx, oy, ly, cnt;
    bit          outside;
    u   = user;
    r   = '0;
    hit = -1;
    for (int i = 0; i < int'(SamNumRules); i++) begin
      if (hit < 0 && addr >= SamMcast[i].start_addr && addr < SamMcast[i].end_addr) hit = i;
    end
    if (hit < 0) begin
      r.decerr  = 1'b1;
      r.num_dst = 13'd1;
      return r;
    end
    r.dst   = SamMcast[hit].idx;
    ox      = int'(SamMcast[hit].mask_x.offset);
    lx      = int'(SamMcast[hit].mask_x.len);
    oy      = int'(SamMcast[hit].mask_y.offset);
    ly      = int'(SamMcast[hit].mask_y.len);
    cnt     = 0;
    outside = 1'b0;
    for (int b = 0; b < 32; b++) begin
      if (u.mcast_mask[b]) begin
        if (b >= ox && b < ox + lx) begin
          r.mask_x[b-ox] = 1'b1;
          cnt++;
        end else if (b >= oy && b < oy + ly) begin
          r.mask_y[b-oy] = 1'b1;
          cnt++;
        end else begin
          outside = 1'b1;
        end
      end
    end
    if (outside || (u.atomic != '0 && u.mcast_mask != '0)) begin
      r.mcast_err = 1'b1;
      r.mask_x    = '0;
      r.mask_y    = '0;
      r.num_dst   = 13'd1;
    end else begin
      r.num_dst = 13'd1 << cnt;
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkDec(input string tag, input logic [7:0] dst, input logic [5:0] mx, input logic [5:0] my,
                          input logic [12:0] num, input logic de, input logic me);
    checkOutput({tag, "_valid"}, 32'(rsp_valid_o), 32'd1);
    checkOutput({tag, "_dst"}, 32'(rsp_dst_o), 32'(dst));
    checkOutput({tag, "_mask_x"}, 32'(rsp_mask_x_o), 32'(mx));
    checkOutput({tag, "_mask_y"}, 32'(rsp_mask_y_o), 32'(my));
    checkOutput({tag, "_num_dst"}, 32'(rsp_num_dst_o), 32'(num));
    checkOutput({tag, "_decerr"}, 32'(rsp_decerr_o), 32'(de));
    checkOutput({tag, "_mcast_err"}, 32'(rsp_mcast_err_o), 32'(me));
  endtask

  // Drives one request for a single cycle; on return the DUT has taken it
  // and the result is expected on the outputs.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] mask, input logic [5:0] atomic);
    @(negedge clk_i);
    req_valid_i = 1'b1;
    req_addr_i  = addr;
    req_user_i  = {mask, atomic};
    @(negedge clk_i);
    req_valid_i = 1'b0;
  endtask

  // Model bookkeeping at the active edge using the pre-edge handshake values.
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exp_q.delete();
      armed = 1'b0;
    end else begin
      bit mready;
      mready = armed && (exp_q.size() < 2);
      if (exp_q.size() != 0 && rsp_ready_i) void'(exp_q.pop_front());
      if (req_valid_i && mready) exp_q.push_back(model(req_addr_i, req_user_i));
      armed = 1'b1;
    end
  end

  // Continuous comparison against the model on every falling edge.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      checkOutput("rst_valid", 32'(rsp_valid_o), 32'd0);
      checkOutput("rst_ready", 32'(req_ready_o), 32'd0);
    end else begin
      checkOutput("valid", 32'(rsp_valid_o), 32'(exp_q.size() != 0));
      checkOutput("ready", 32'(req_ready_o), 32'(armed && exp_q.size() < 2));
      if (exp_q.size() != 0) begin
        checkOutput("dst", 32'(rsp_dst_o), 32'(exp_q[0].dst));
        checkOutput("mask_x", 32'(rsp_mask_x_o), 32'(exp_q[0].mask_x));
        checkOutput("mask_y", 32'(rsp_mask_y_o), 32'(exp_q[0].mask_y));
        checkOutput("num_dst", 32'(rsp_num_dst_o), 32'(exp_q[0].num_dst));
        checkOutput("decerr", 32'(rsp_decerr_o), 32'(exp_q[0].decerr));
        checkOutput("mcast_err", 32'(rsp_mcast_err_o), 32'(exp_q[0].mcast_err));
      end
    end
  end

  initial begin
    mcast_dec_t m;

    // Hand-derived pins on the reference model itself.
    m = model(32'h2000_0000, {32'h003C_0000, 6'h00});
    checkOutput("pin_num16", 32'(m.num_dst), 32'd16);
    checkOutput("pin_my3", 32'(m.mask_y), 32'd3);
    m = model(32'h2004_0000, {32'h0005_0000, 6'h00});
    checkOutput("pin_end_dst", 32'(m.dst), 32'h22);
    checkOutput("pin_r1_mx", 32'(m.mask_x), 32'd5);
    m = model(32'h2000_0000, {32'h0100_0000, 6'h00});
    checkOutput("pin_err", 32'(m.mcast_err), 32'd1);
    m = model(32'hFFFF_0000, {32'h0000_0000, 6'h00});
    checkOutput("pin_decerr_num", 32'(m.num_dst), 32'd1);

    // Reset state.
    @(negedge clk_i);
    checkOutput("rst_dst", 32'(rsp_dst_o), 32'd0);
    checkOutput("rst_num", 32'(rsp_num_dst_o), 32'd0);
    repeat (2) @(negedge clk_i);
    #2 rst_ni = 1'b1;
    @(negedge clk_i);
    checkOutput("ready_after_rst", 32'(req_ready_o), 32'd1);

    // Directed decodes with hand-computed results.
    rsp_ready_i = 1'b1;
    applyStimulus(32'h2000_0000, 32'h0000_0000, 6'h00); checkDec("d_plain",   8'h11, 6'd0, 6'd0, 13'd1,  1'b0, 1'b0);
    applyStimulus(32'h2000_0000, 32'h0030_0000, 6'h00); checkDec("d_x11",     8'h11, 6'd3, 6'd0, 13'd4,  1'b0, 1'b0);
    applyStimulus(32'h2000_0000, 32'h003C_0000, 6'h00); checkDec("d_xy",      8'h11, 6'd3, 6'd3, 13'd16, 1'b0, 1'b0);
    // Bits 22/23 lie outside both fields of rule 0.
    applyStimulus(32'h2000_0000, 32'h00F0_0000, 6'h00); checkDec("d_f0",      8'h11, 6'd0, 6'd0, 13'd1,  1'b0, 1'b1);
    applyStimulus(32'h2000_0000, 32'h0100_0000, 6'h00); checkDec("d_out",     8'h11, 6'd0, 6'd0, 13'd1,  1'b0, 1'b1);
    applyStimulus(32'hFFFF_0000, 32'h0000_0000, 6'h00); checkDec("d_unmap",   8'h00, 6'd0, 6'd0, 13'd1,  1'b1, 1'b0);
    applyStimulus(32'h2004_0000, 32'h0005_0000, 6'h00); checkDec("d_endaddr", 8'h22, 6'd5, 6'd0, 13'd4,  1'b0, 1'b0);
    applyStimulus(32'h2000_0000, 32'h0010_0000, 6'h21); checkDec("d_atomic",  8'h11, 6'd0, 6'd0, 13'd1,  1'b0, 1'b1);
    applyStimulus(32'h7000_0000, 32'h0000_0001, 6'h00); checkDec("d_len0",    8'h33, 6'd0, 6'd0, 13'd1,  1'b0, 1'b1);
    applyStimulus(32'h2003_FFFF, 32'h0008_0000, 6'h00); checkDec("d_last",    8'h11, 6'd0, 6'd2, 13'd2,  1'b0, 1'b0);

    // Backpressure: two requests fill the buffer, the third is refused.
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b1; req_addr_i = 32'h2000_0000; req_user_i = {32'h0030_0000, 6'h00};
    @(negedge clk_i);
    req_addr_i = 32'h2004_0000; req_user_i = {32'h0000_0000, 6'h00};
    @(negedge clk_i);
    req_addr_i = 32'hFFFF_0000;
    checkOutput("bp_full_ready", 32'(req_ready_o), 32'd0);
    checkOutput("bp_hold_dst", 32'(rsp_dst_o), 32'h11);
    @(negedge clk_i);
    checkOutput("bp_full_ready2", 32'(req_ready_o), 32'd0);
    checkOutput("bp_hold_num", 32'(rsp_num_dst_o), 32'd4);
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    checkOutput("bp_drain_b", 32'(rsp_dst_o), 32'h22);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    checkOutput("bp_drain_c", 32'(rsp_decerr_o), 32'd1);
    @(negedge clk_i);
    checkOutput("bp_empty", 32'(rsp_valid_o), 32'd0);

    // Reset while full drops both entries.
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b1; req_addr_i = 32'h2000_0000; req_user_i = {32'h003C_0000, 6'h00};
    repeat (2) @(negedge clk_i);
    req_valid_i = 1'b0;
    checkOutput("rf_full", 32'(req_ready_o), 32'd0);
    #2 rst_ni = 1'b0;
    #1;
    checkOutput("rf_valid_now", 32'(rsp_valid_o), 32'd0);
    checkOutput("rf_ready_now", 32'(req_ready_o), 32'd0);
    checkOutput("rf_dst_now", 32'(rsp_dst_o), 32'd0);
    checkOutput("rf_num_now", 32'(rsp_num_dst_o), 32'd0);
    repeat (2) @(negedge clk_i);
    #2 rst_ni = 1'b1;
    @(negedge clk_i);
    checkOutput("rf_ready_rel", 32'(req_ready_o), 32'd1);
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    checkOutput("rf_no_stale", 32'(rsp_valid_o), 32'd0);

    // Randomized traffic with alternating light/heavy backpressure.
    for (int c = 0; c < 800; c++) begin
      logic [31:0] a, mk;
      logic [5:0]  at;
      @(negedge clk_i);
      case ($urandom_range(0, 5))
        0:       a = 32'h2000_0000 + ($urandom & 32'h0003_FFFF);
        1:       a = 32'h2004_0000;
        2:       a = 32'h2003_FFFF;
        3:       a = 32'h2000_0000 + ($urandom & 32'h0FFF_FFFF);
        4:       a = 32'h7000_0000 + ($urandom & 32'h0001_FFFF);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0:       mk = 32'h0;
        1:       mk = $urandom & 32'h003C_0000;
        2:       mk = $urandom & 32'h0007_1000;
        3:       mk = 32'h1 << $urandom_range(0, 31);
        default: mk = $urandom;
      endcase
      at = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'h00;
      req_valid_i = ($urandom_range(0, 3) != 0);
      req_addr_i  = a;
      req_user_i  = {mk, at};
      rsp_ready_i = ($urandom_range(0, 9) < (((c / 100) % 2 == 0) ? 8 : 3));
    end
    @(negedge clk_i);
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    repeat (4) @(negedge clk_i);
    checkOutput("final_empty", 32'(rsp_valid_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
